// File: rtl/matmul_10x10_ctrl.sv
// Sequencer for C = A x B on 10x10 storage blocks: streams A row / B column reads,
// multiply-accumulates each dot product and writes it to C, 12 cycles per element.
module matmul_10x10_ctrl #(
  parameter int DATA_WIDTH = 8,
  parameter int ACC_WIDTH  = 20
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  abort,
  output logic                  busy,
  output logic                  done,
  output logic                  a_en_ReadMat,
  output logic [3:0]            a_rowAddr,
  output logic [3:0]            a_colAddr,
  input  logic [DATA_WIDTH-1:0] a_readData,
  output logic                  b_en_ReadMat,
  output logic [3:0]            b_rowAddr,
  output logic [3:0]            b_colAddr,
  input  logic [DATA_WIDTH-1:0] b_readData,
  output logic                  c_en_WriteMat,
  output logic [3:0]            c_rowAddr,
  output logic [3:0]            c_colAddr,
  output logic [ACC_WIDTH-1:0]  c_writeData
);

  typedef enum logic [2:0] {IDLE, RUN, DRAIN, WRITE, DONE} state_t;

  state_t                  state_q;
  logic [3:0]              i_q, j_q, k_q;
  logic [3:0]              i_d, j_d, k_d;
  logic [ACC_WIDTH-1:0]    acc_q, acc_d;
  logic                    v_q;
  logic                    busy_q, done_q, a_en_q, b_en_q, c_en_q;
  logic [3:0]              a_row_q, a_col_q, b_row_q, b_col_q, c_row_q, c_col_q;
  logic [2*DATA_WIDTH-1:0] prod;
  logic                    last_elem;

  // Read data lags the address by one cycle, so v_q marks when it belongs to a valid k.
  always_comb begin
    prod      = a_readData * b_readData;
    acc_d     = v_q ? acc_q + ACC_WIDTH'(prod) : acc_q;
    k_d       = k_q + 4'd1;
    j_d       = (j_q == 4'd9) ? 4'd0 : j_q + 4'd1;
    i_d       = (j_q == 4'd9) ? i_q + 4'd1 : i_q;
    last_elem = (i_q == 4'd9) && (j_q == 4'd9);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      i_q     <= '0;
      j_q     <= '0;
      k_q     <= '0;
      acc_q   <= '0;
      v_q     <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      a_en_q  <= 1'b0;
      b_en_q  <= 1'b0;
      c_en_q  <= 1'b0;
      a_row_q <= '0;
      a_col_q <= '0;
      b_row_q <= '0;
      b_col_q <= '0;
      c_row_q <= '0;
      c_col_q <= '0;
    end else begin
      // Outputs are registered for the state being entered; anything not set below idles at 0.
      done_q  <= 1'b0;
      a_en_q  <= 1'b0;
      b_en_q  <= 1'b0;
      c_en_q  <= 1'b0;
      a_row_q <= '0;
      a_col_q <= '0;
      b_row_q <= '0;
      b_col_q <= '0;
      c_row_q <= '0;
      c_col_q <= '0;
      if (abort && state_q != IDLE) begin
        state_q <= IDLE;
        i_q     <= '0;
        j_q     <= '0;
        k_q     <= '0;
        acc_q   <= '0;
        v_q     <= 1'b0;
        busy_q  <= 1'b0;
      end else begin
        case (state_q)
          IDLE: begin
            if (start) begin
              state_q <= RUN;
              i_q     <= '0;
              j_q     <= '0;
              k_q     <= '0;
              acc_q   <= '0;
              v_q     <= 1'b0;
              busy_q  <= 1'b1;
              a_en_q  <= 1'b1;
              b_en_q  <= 1'b1;
            end
          end
          RUN: begin
            v_q   <= 1'b1;
            acc_q <= acc_d;
            if (k_q == 4'd9) begin
              state_q <= DRAIN;
            end else begin
              k_q     <= k_d;
              a_en_q  <= 1'b1;
              b_en_q  <= 1'b1;
              a_row_q <= i_q;
              a_col_q <= k_d;
              b_row_q <= k_d;
              b_col_q <= j_q;
            end
          end
          DRAIN: begin
            acc_q   <= acc_d;
            state_q <= WRITE;
            c_en_q  <= 1'b1;
            c_row_q <= i_q;
            c_col_q <= j_q;
          end
          WRITE: begin
            acc_q <= '0;
            v_q   <= 1'b0;
            k_q   <= '0;
            if (last_elem) begin
              state_q <= DONE;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              i_q     <= '0;
              j_q     <= '0;
            end else begin
              state_q <= RUN;
              i_q     <= i_d;
              j_q     <= j_d;
              a_en_q  <= 1'b1;
              b_en_q  <= 1'b1;
              a_row_q <= i_d;
              b_col_q <= j_d;
            end
          end
          DONE:    state_q <= IDLE;
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign busy          = busy_q;
  assign done          = done_q;
  assign a_en_ReadMat  = a_en_q;
  assign a_rowAddr     = a_row_q;
  assign a_colAddr     = a_col_q;
  assign b_en_ReadMat  = b_en_q;
  assign b_rowAddr     = b_row_q;
  assign b_colAddr     = b_col_q;
  assign c_en_WriteMat = c_en_q;
  assign c_rowAddr     = c_row_q;
  assign c_colAddr     = c_col_q;
  assign c_writeData   = acc_q;

endmodule

// File: tb/tb_matmul_10x10_ctrl.sv
// Self-checking bench for matmul_10x10_ctrl: registered A/B storage models, C capture,
// table of expected C elements per pattern plus abort, reset and start-spam sequences.
module tb_matmul_10x10_ctrl;

  logic        clk = 1'b0;
  logic        rst_n, start, abort;
  logic        busy, done;
  logic        a_en, b_en, c_en;
  logic [3:0]  a_row, a_col, b_row, b_col, c_row, c_col;
  logic [7:0]  a_rd, b_rd;
  logic [19:0] c_wd;

  matmul_10x10_ctrl #(.DATA_WIDTH(8), .ACC_WIDTH(20)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .busy(busy), .done(done),
    .a_en_ReadMat(a_en), .a_rowAddr(a_row), .a_colAddr(a_col), .a_readData(a_rd),
    .b_en_ReadMat(b_en), .b_rowAddr(b_row), .b_colAddr(b_col), .b_readData(b_rd),
    .c_en_WriteMat(c_en), .c_rowAddr(c_row), .c_colAddr(c_col), .c_writeData(c_wd)
  );

  always #5 clk = ~clk;

  typedef struct {
    int pat;
    int r;
    int c;
    int exp;
  } vec_t;
  vec_t vecs[11];

  logic [7:0]  A [10][10];
  logic [7:0]  B [10][10];
  logic [19:0] cw [10][10];
  int          cstamp [10][10];

  int cyc = 0, base = 0, base_wr = 0;
  int tot_wr = 0, tot_done = 0, tot_busy = 0, ord_err = 0, addr_err = 0, done_rel = -1, mon_n;
  int s_wr, s_done, s_busy, s_ord, s_addr;
  int pass_cnt = 0, total_cnt = 0;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (a_en && a_row < 10 && a_col < 10) a_rd <= A[a_row][a_col];
    if (b_en && b_row < 10 && b_col < 10) b_rd <= B[b_row][b_col];
  end

  // Capture writes away from the edge and check row-major order and 12-cycle spacing.
  always @(negedge clk) begin
    if (c_en) begin
      mon_n = tot_wr - base_wr;
      if (c_row != 4'(mon_n / 10) || c_col != 4'(mon_n % 10) || (cyc - base) != 12 * mon_n + 12)
        ord_err++;
      if (c_row < 10 && c_col < 10) begin
        cw[c_row][c_col]     = c_wd;
        cstamp[c_row][c_col] = tot_wr + 1;
      end
      tot_wr++;
    end
    if (done) begin
      tot_done++;
      done_rel = cyc - base;
    end
    if (busy) tot_busy++;
    if (a_row > 9 || a_col > 9 || b_row > 9 || b_col > 9 || c_row > 9 || c_col > 9) addr_err++;
  end

  task automatic check(input string name, input longint act, input longint exp);
    total_cnt++;
    if (act == exp) pass_cnt++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  function automatic int exp_c(input int p, input int r, input int c);
    case (p)
      0:       return 10 * r + c;
      1:       return 650250;
      default: return 10 * (r + 1) * (c + 1);
    endcase
  endfunction

  task automatic load(input int p);
    for (int r = 0; r < 10; r++)
      for (int c = 0; c < 10; c++) begin
        case (p)
          0: begin A[r][c] = (r == c) ? 8'd1 : 8'd0; B[r][c] = 8'(10 * r + c); end
          1: begin A[r][c] = 8'd255; B[r][c] = 8'd255; end
          default: begin A[r][c] = 8'(r + 1); B[r][c] = 8'(c + 1); end
        endcase
      end
  endtask

  task automatic begin_run();
    @(negedge clk);
    s_wr = tot_wr; s_done = tot_done; s_busy = tot_busy; s_ord = ord_err; s_addr = addr_err;
    base_wr = tot_wr;
    base = cyc;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic run(input bit spam);
    bit seen = 0;
    begin_run();
    for (int t = 0; t < 1300 && !seen; t++) begin
      @(negedge clk);
      if (done) seen = 1;
      start = spam && !seen && (t % 3 == 0);
    end
    start = 1'b0;
    check("done_seen", seen, 1);
    repeat (30) @(negedge clk);
  endtask

  task automatic check_run(input string tag, input int p);
    int bad = 0;
    check({tag, "_writes"}, tot_wr - s_wr, 100);
    check({tag, "_done_pulses"}, tot_done - s_done, 1);
    check({tag, "_done_cycle"}, done_rel, 1201);
    check({tag, "_busy_cycles"}, tot_busy - s_busy, 1200);
    check({tag, "_order_errs"}, ord_err - s_ord, 0);
    check({tag, "_addr_errs"}, addr_err - s_addr, 0);
    for (int r = 0; r < 10; r++)
      for (int c = 0; c < 10; c++)
        if (cstamp[r][c] <= s_wr || int'(cw[r][c]) != exp_c(p, r, c)) bad++;
    check({tag, "_matrix_bad_elems"}, bad, 0);
    for (int v = 0; v < 11; v++)
      if (vecs[v].pat == p) check($sformatf("%s_C[%0d][%0d]", tag, vecs[v].r, vecs[v].c),
                                  cw[vecs[v].r][vecs[v].c], vecs[v].exp);
  endtask

  initial begin
    vecs[0]  = '{0, 0, 0, 0};
    vecs[1]  = '{0, 3, 7, 37};
    vecs[2]  = '{0, 9, 9, 99};
    vecs[3]  = '{0, 5, 0, 50};
    vecs[4]  = '{1, 0, 0, 650250};
    vecs[5]  = '{1, 9, 9, 650250};
    vecs[6]  = '{1, 4, 6, 650250};
    vecs[7]  = '{2, 0, 0, 10};
    vecs[8]  = '{2, 9, 9, 1000};
    vecs[9]  = '{2, 2, 5, 180};
    vecs[10] = '{2, 9, 0, 100};
    for (int r = 0; r < 10; r++)
      for (int c = 0; c < 10; c++) begin cw[r][c] = '0; cstamp[r][c] = 0; end

    rst_n = 1'b0; start = 1'b0; abort = 1'b0;
    #1;
    check("reset_busy_done", {busy, done}, 0);
    check("reset_enables", {a_en, b_en, c_en}, 0);
    check("reset_addrs", {a_row, a_col, b_row, b_col, c_row, c_col}, 0);
    check("reset_cdata", c_wd, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    for (int p = 0; p < 3; p++) begin
      load(p);
      run(1'b0);
      check_run($sformatf("pat%0d", p), p);
    end

    load(1);
    run(1'b1);
    check_run("spam", 1);

    // Abort sampled at the edge ending cycle 300, which is the WRITE of element 24 (C[2][4]).
    load(2);
    begin_run();
    for (int t = 0; t < 400 && (cyc - base) < 300; t++) @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("abort_idle_301", {busy, a_en, b_en, c_en}, 0);
    @(negedge clk);
    check("abort_busy_302", busy, 0);
    repeat (20) @(negedge clk);
    check("abort_writes", tot_wr - s_wr, 25);
    check("abort_done", tot_done - s_done, 0);
    check("abort_C24_written", cstamp[2][4] > s_wr, 1);
    check("abort_C24_value", cw[2][4], 150);
    check("abort_C25_unwritten", cstamp[2][5] > s_wr, 0);
    load(0);
    run(1'b0);
    check_run("post_abort", 0);

    // Reset dropped between edges mid-run with large operands, then a clean identity run.
    load(1);
    begin_run();
    for (int t = 0; t < 600 && (cyc - base) < 500; t++) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("rst_mid_busy_done", {busy, done}, 0);
    check("rst_mid_enables", {a_en, b_en, c_en}, 0);
    check("rst_mid_cdata", c_wd, 0);
    s_wr = tot_wr; s_done = tot_done;
    repeat (5) @(negedge clk);
    check("rst_mid_no_writes", tot_wr - s_wr, 0);
    check("rst_mid_no_done", tot_done - s_done, 0);
    rst_n = 1'b1;
    load(0);
    run(1'b0);
    check_run("post_reset", 0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
